// File: rtl/cbus_pkg.sv
// Shared CBus types for the arbiter: request/response bundles, burst codes,
// arbiter state encoding and a small index helper.
package cbus_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [7:0]        len;
    logic [7:0]        wstrobe;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] rdata;
  } cbus_resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Increment with wrap at n, so a non-power-of-two requester count never
  // lands the pointer on a nonexistent index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of requester-side and memory-side CBus signals around the arbiter.
// Valid/ready: a requester holds valid and payload stable until it sees ready && last.
interface cbus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  logic [63:0]        req_addr    [NUM_REQ];
  logic [63:0]        req_wdata   [NUM_REQ];
  logic [2:0]         req_size    [NUM_REQ];
  logic [1:0]         req_burst   [NUM_REQ];
  logic [7:0]         req_len     [NUM_REQ];
  logic [7:0]         req_wstrobe [NUM_REQ];
  logic [63:0]        req_rdata   [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_last;

  logic        mem_valid;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [2:0]  mem_size;
  logic [1:0]  mem_burst;
  logic [7:0]  mem_len;
  logic [7:0]  mem_wstrobe;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        mem_last;

  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_size, req_burst, req_len, req_wstrobe,
    output req_rdata, req_ready, req_last,
    output mem_valid, mem_addr, mem_wdata, mem_size, mem_burst, mem_len, mem_wstrobe,
    input  mem_rdata, mem_ready, mem_last,
    output grant_valid, grant_idx
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_size, req_burst, req_len, req_wstrobe,
    input  req_rdata, req_ready, req_last,
    input  mem_valid, mem_addr, mem_wdata, mem_size, mem_burst, mem_len, mem_wstrobe,
    output mem_rdata, mem_ready, mem_last,
    input  grant_valid, grant_idx
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set bit of valid at or above start,
// otherwise the lowest set bit (wrap-around).
module rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic             hit_hi;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  always_comb begin
    found  = 1'b0;
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    // Descending scan so the lowest qualifying index is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        found  = 1'b1;
        idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= start) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end
      end
    end
    idx = hit_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one CBus master port among NUM_REQ requesters;
// the owner keeps the port until the memory side returns ready && last.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  cbus_arbiter_if.slave    bus,
  output arb_state_t       dbg_state,
  output logic [IDX_W-1:0] dbg_rr_ptr
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  cbus_req_t        reqs [NUM_REQ];
  cbus_req_t        sel;
  cbus_resp_t       resp [NUM_REQ];

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (bus.req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state       <= ST_BUSY;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (bus.mem_ready && bus.mem_last) begin
            state       <= ST_IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= IDX_W'(wrap_inc(int'(grant_idx), NUM_REQ));
          end
        end
      endcase
    end
  end

  // Request path: the owner's bundle passes through untouched while BUSY.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i] = '{valid:   bus.req_valid[i],
                  addr:    bus.req_addr[i],
                  wdata:   bus.req_wdata[i],
                  size:    bus.req_size[i],
                  burst:   bus.req_burst[i],
                  len:     bus.req_len[i],
                  wstrobe: bus.req_wstrobe[i]};
    end
    sel = '0;
    if (state == ST_BUSY) sel = reqs[grant_idx];
  end

  assign bus.mem_valid   = sel.valid;
  assign bus.mem_addr    = sel.addr;
  assign bus.mem_wdata   = sel.wdata;
  assign bus.mem_size    = sel.size;
  assign bus.mem_burst   = sel.burst;
  assign bus.mem_len     = sel.len;
  assign bus.mem_wstrobe = sel.wstrobe;

  // Response path: only the owner sees the memory response, same cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      resp[i] = '0;
      if (state == ST_BUSY && grant_idx == IDX_W'(i)) begin
        resp[i] = '{ready: bus.mem_ready, last: bus.mem_last, rdata: bus.mem_rdata};
      end
      bus.req_ready[i] = resp[i].ready;
      bus.req_last[i]  = resp[i].last;
      bus.req_rdata[i] = resp[i].rdata;
    end
  end

  assign bus.grant_valid = grant_valid;
  assign bus.grant_idx   = grant_idx;
  assign dbg_state       = state;
  assign dbg_rr_ptr      = rr_ptr;

`ifndef SYNTHESIS
  // The owner must keep its request up until the final beat completes.
  a_owner_holds_valid: assert property (
    @(posedge clk) disable iff (reset) (state == ST_BUSY) |-> bus.req_valid[grant_idx]
  );
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scenario bench for cbus_arbiter: expected forwarded addresses queue up as
// requests are driven and are popped when the arbiter puts them on the mem port.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  arb_state_t       dbg_state;
  logic [IDX_W-1:0] dbg_rr_ptr;

  logic [63:0] exp_q[$];
  logic [63:0] exp;
  int errors = 0;
  int checks = 0;

  cbus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cbus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i]    = '0;
      bus.req_wdata[i]   = '0;
      bus.req_size[i]    = '0;
      bus.req_burst[i]   = '0;
      bus.req_len[i]     = '0;
      bus.req_wstrobe[i] = '0;
    end
    bus.mem_ready = 1'b0;
    bus.mem_last  = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_req(input int i, input logic [63:0] addr, input logic [7:0] len,
                           input logic [7:0] wstrobe);
    bus.req_valid[i]   = 1'b1;
    bus.req_addr[i]    = addr;
    bus.req_wdata[i]   = ~addr;
    bus.req_size[i]    = 3'd3;
    bus.req_burst[i]   = BURST_INCR;
    bus.req_len[i]     = len;
    bus.req_wstrobe[i] = wstrobe;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (bus.mem_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    drive_req(0, 64'h1234, 8'd0, 8'd0);
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (dbg_rr_ptr !== '0) begin errors++; $display("FAIL reset_rr_ptr got=%0d exp=0", dbg_rr_ptr); end
    checks++; if (bus.grant_valid !== 1'b0 || bus.grant_idx !== '0) begin errors++; $display("FAIL reset_grant got=%b/%0d exp=0/0", bus.grant_valid, bus.grant_idx); end
    checks++; if (bus.mem_valid !== 1'b0 || bus.mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem got=%b/%h exp=0/0", bus.mem_valid, bus.mem_addr); end
    checks++; if (bus.req_ready !== '0 || bus.req_last !== '0) begin errors++; $display("FAIL reset_req_resp got=%b/%b exp=0/0", bus.req_ready, bus.req_last); end
    clear_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    drive_req(0, 64'h8000_0000, 8'd0, 8'd0);
    exp_q.push_back(64'h8000_0000);
    tick();
    exp = exp_q.pop_front();
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL single_latency got=%b exp=1", bus.mem_valid); end
    checks++; if (bus.mem_addr !== exp) begin errors++; $display("FAIL single_addr got=%h exp=%h", bus.mem_addr, exp); end
    checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 1'b0) begin errors++; $display("FAIL single_grant got=%b/%0d exp=1/0", bus.grant_valid, bus.grant_idx); end
    checks++; if (bus.req_ready[0] !== 1'b0) begin errors++; $display("FAIL single_early_ready got=%b exp=0", bus.req_ready[0]); end
    tick();
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_last  = 1'b1;
    bus.mem_rdata = 64'hDEAD_BEEF;
    #1;
    checks++; if (bus.req_ready[0] !== 1'b1 || bus.req_last[0] !== 1'b1) begin errors++; $display("FAIL single_resp got=%b/%b exp=1/1", bus.req_ready[0], bus.req_last[0]); end
    checks++; if (bus.req_rdata[0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", bus.req_rdata[0]); end
    checks++; if (bus.req_ready[1] !== 1'b0 || bus.req_rdata[1] !== 64'h0) begin errors++; $display("FAIL single_other got=%b/%h exp=0/0", bus.req_ready[1], bus.req_rdata[1]); end
    tick();
    clear_inputs();
    #1;
    checks++; if (dbg_state !== ST_IDLE || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL single_release got=%0d/%b exp=0/0", dbg_state, bus.mem_valid); end
    checks++; if (dbg_rr_ptr !== 1'b1) begin errors++; $display("FAIL single_rr_ptr got=%0d exp=1", dbg_rr_ptr); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_req(0, 64'hA000, 8'd0, 8'd0);
    drive_req(1, 64'hB000, 8'd0, 8'd0);
    exp_q.push_back(64'hA000);
    exp_q.push_back(64'hB000);
    tick();
    exp = exp_q.pop_front();
    checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== exp) begin errors++; $display("FAIL simul_first got=%b/%h exp=1/%h", bus.mem_valid, bus.mem_addr, exp); end
    checks++; if (bus.grant_idx !== 1'b0) begin errors++; $display("FAIL simul_first_idx got=%0d exp=0", bus.grant_idx); end
    bus.mem_ready = 1'b1;
    bus.mem_last  = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL simul_ready got=%b exp=01", bus.req_ready); end
    tick();
    bus.req_valid[0] = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.mem_last     = 1'b0;
    #1;
    checks++; if (bus.mem_valid !== 1'b0 || bus.grant_valid !== 1'b0) begin errors++; $display("FAIL simul_gap got=%b/%b exp=0/0", bus.mem_valid, bus.grant_valid); end
    tick();
    exp = exp_q.pop_front();
    checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== exp) begin errors++; $display("FAIL simul_second got=%b/%h exp=1/%h", bus.mem_valid, bus.mem_addr, exp); end
    checks++; if (bus.grant_idx !== 1'b1) begin errors++; $display("FAIL simul_second_idx got=%0d exp=1", bus.grant_idx); end
    bus.mem_ready = 1'b1;
    bus.mem_last  = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_burst();
    bit ok;
    drive_req(1, 64'h2000, 8'd3, 8'hFF);
    exp_q.push_back(64'h2000);
    wait_grant(ok);
    exp = exp_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got=no_grant exp=grant"); end
    checks++; if (bus.mem_addr !== exp || bus.grant_idx !== 1'b1) begin errors++; $display("FAIL burst_addr got=%h/%0d exp=%h/1", bus.mem_addr, bus.grant_idx, exp); end
    checks++; if (bus.mem_len !== 8'd3 || bus.mem_wstrobe !== 8'hFF || bus.mem_wdata !== ~exp) begin errors++; $display("FAIL burst_payload got=%h/%h/%h", bus.mem_len, bus.mem_wstrobe, bus.mem_wdata); end
    for (int b = 0; b < 4; b++) begin
      bus.mem_ready = 1'b1;
      bus.mem_last  = (b == 3);
      bus.mem_rdata = 64'(b);
      #1;
      checks++; if (bus.req_ready[1] !== 1'b1 || bus.req_last[1] !== (b == 3)) begin errors++; $display("FAIL burst_beat%0d got=%b/%b exp=1/%b", b, bus.req_ready[1], bus.req_last[1], b == 3); end
      tick();
      if (b == 3) begin
        clear_inputs();
        #1;
        checks++; if (dbg_state !== ST_IDLE || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL burst_release got=%0d/%b exp=0/0", dbg_state, bus.mem_valid); end
      end else begin
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 1'b1 || bus.mem_valid !== 1'b1) begin errors++; $display("FAIL burst_hold%0d got=%b/%0d/%b exp=1/1/1", b, bus.grant_valid, bus.grant_idx, bus.mem_valid); end
      end
    end
    tick();
  endtask

  task automatic test_fairness();
    bit ok;
    logic [63:0] a;
    do_reset();
    exp_q.delete();
    for (int r = 0; r < NUM_REQ; r++) begin
      a = {$urandom, $urandom};
      drive_req(r, a, 8'd0, 8'd0);
      exp_q.push_back(a);
    end
    for (int t = 0; t < 6; t++) begin
      wait_grant(ok);
      exp = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL fair_timeout%0d got=no_grant exp=grant", t); end
      checks++; if (bus.grant_idx !== IDX_W'(t % 2)) begin errors++; $display("FAIL fair_grant%0d got=%0d exp=%0d", t, bus.grant_idx, t % 2); end
      checks++; if (bus.mem_addr !== exp) begin errors++; $display("FAIL fair_addr%0d got=%h exp=%h", t, bus.mem_addr, exp); end
      bus.mem_ready = 1'b1;
      bus.mem_last  = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_last  = 1'b0;
      a = {$urandom, $urandom};
      bus.req_addr[t % 2]  = a;
      bus.req_wdata[t % 2] = ~a;
      exp_q.push_back(a);
    end
    clear_inputs();
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    drive_req(0, 64'h3000, 8'd0, 8'd0);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_last  = 1'b1;
    tick();
    clear_inputs();
    drive_req(1, 64'h4000, 8'd7, 8'hFF);
    wait_grant(ok);
    checks++; if (!ok || bus.grant_idx !== 1'b1 || dbg_rr_ptr !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b/%0d/%0d exp=1/1/1", ok, bus.grant_idx, dbg_rr_ptr); end
    for (int b = 0; b < 2; b++) begin
      bus.mem_ready = 1'b1;
      tick();
    end
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++; if (bus.mem_valid !== 1'b0 || bus.grant_valid !== 1'b0) begin errors++; $display("FAIL midrst_mem got=%b/%b exp=0/0", bus.mem_valid, bus.grant_valid); end
    checks++; if (dbg_rr_ptr !== '0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state got=%0d/%0d exp=0/0", dbg_rr_ptr, dbg_state); end
    reset = 1'b0;
    drive_req(1, 64'h5000, 8'd0, 8'd0);
    exp_q.push_back(64'h5000);
    tick();
    exp = exp_q.pop_front();
    checks++; if (bus.mem_valid !== 1'b1 || bus.grant_idx !== 1'b1 || bus.mem_addr !== exp) begin errors++; $display("FAIL midrst_after got=%b/%0d/%h exp=1/1/%h", bus.mem_valid, bus.grant_idx, bus.mem_addr, exp); end
    bus.mem_ready = 1'b1;
    bus.mem_last  = 1'b1;
    tick();
    clear_inputs();
    #1;
    checks++; if (dbg_rr_ptr !== '0) begin errors++; $display("FAIL midrst_wrap got=%0d exp=0", dbg_rr_ptr); end
    tick();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_last  = 1'($urandom_range(0, 1));
      bus.mem_rdata = {$urandom, $urandom};
      bus.req_addr[c % 2] = {$urandom, $urandom};
      #1;
      checks++;
      if (bus.mem_valid !== 1'b0 || bus.mem_addr !== 64'h0 || bus.grant_valid !== 1'b0 ||
          bus.req_ready !== '0 || bus.req_last !== '0 || bus.req_rdata[0] !== 64'h0 ||
          bus.req_rdata[1] !== 64'h0 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL idle_c%0d got=v%b a%h g%b r%b l%b s%0d exp=all_zero", c, bus.mem_valid,
                 bus.mem_addr, bus.grant_valid, bus.req_ready, bus.req_last, dbg_state);
      end
      tick();
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    tick();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst();
    test_fairness();
    test_reset_mid_burst();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter sharing one CBus master port among `NUM_REQ` CBus requesters (default 2: instruction fetch, data access). Sits between the CPU's requesters and `cbus_crossbar`; grants one requester at a time, forwards its request unchanged, and routes the response back until the transaction's final beat completes.

## Interface
- `NUM_REQ`, 2, number of requesters (≥2)
- `IDX_W`, `$clog2(NUM_REQ)`, grant index width (derived, not overridden)

- `clk` in 1: clock, single domain
- `reset` in 1: synchronous, active-high
- `req_valid` in [NUM_REQ]: requester request valid
- `req_addr` in [NUM_REQ][63:0]: address
- `req_wdata` in [NUM_REQ][63:0]: write data
- `req_size` in [NUM_REQ][2:0]: access size
- `req_burst` in [NUM_REQ][1:0]: burst type
- `req_len` in [NUM_REQ][7:0]: beats − 1
- `req_wstrobe` in [NUM_REQ][7:0]: byte strobes; 0 = read
- `req_rdata` out [NUM_REQ][63:0]: read data
- `req_ready` out [NUM_REQ]: beat accepted / data valid
- `req_last` out [NUM_REQ]: final beat
- `mem_valid`, `mem_addr`, `mem_wdata`, `mem_size`, `mem_burst`, `mem_len`, `mem_wstrobe` out: shared request, same widths as `req_*`
- `mem_rdata` in 64, `mem_ready` in 1, `mem_last` in 1: shared response
- `grant_valid` out 1: a transaction is owned
- `grant_idx` out IDX_W: owner index

## Operation
- States: IDLE, BUSY.
- IDLE: all `mem_*` request outputs 0, all `req_ready`/`req_last` 0, `req_rdata` 0. If any `req_valid`, pick first set index searching from `rr_ptr` upward with wrap; register `grant_idx`, go BUSY. No valid → stay IDLE.
- BUSY: `mem_*` = `req_*[grant_idx]` combinationally; `req_ready[grant_idx]` = `mem_ready`, `req_last[grant_idx]` = `mem_last`, `req_rdata[grant_idx]` = `mem_rdata`; non-granted requesters see ready/last/rdata = 0.
- Release: cycle with `mem_ready && mem_last` → IDLE next cycle, `rr_ptr` ← `grant_idx + 1` (wrap at NUM_REQ, not at 2^IDX_W).
- `mem_ready` without `mem_last` (burst beat): stay BUSY, grant held.
- Requester obligation: hold `req_valid` and payload stable from assertion until its `ready && last`. Granted requester dropping `req_valid` in BUSY is a protocol violation: arbiter keeps grant; simulation-only assertion fires.
- Losing requesters stall with `req_ready` = 0; no request state is buffered inside the arbiter.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ−1,0.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_idx` 0, `grant_valid` 0, all outputs 0.
- Reset while BUSY: next cycle IDLE, `mem_valid` 0; in-flight transaction abandoned (downstream is reset by the same signal).
- Arbitration latency: `req_valid` rising in IDLE at cycle N → `mem_valid` high at N+1.
- Response path combinational: `mem_ready`/`mem_last`/`mem_rdata` reach the owner in the same cycle.
- Release overhead: one IDLE cycle between consecutive transactions; a request waiting at release is granted at release+1, forwarded at release+2.
- `grant_valid` = (state == BUSY), registered.

## Structure
- `cbus_pkg`: `cbus_req_t` (valid, addr, wdata, size, burst, len, wstrobe), `cbus_resp_t` (ready, last, rdata), `ADDR_W`/`DATA_W` = 64, burst encodings. Ports stay flat for `.*` hookup at top level; internal muxing uses the structs.
- One sub-module: `rr_picker` — combinational round-robin selector (valid vector, start pointer → found, index).

## Test plan
- Single read: req0 valid, addr 0x8000_0000, len 0; mem ready+last at cycle 3 with rdata 0xDEAD_BEEF → req_ready[0]/req_last[0]/rdata seen that cycle, IDLE next cycle, rr_ptr 1.
- Simultaneous: req0, req1 valid at cycle 0 after reset → req0 granted (mem_addr = req_addr[0] at cycle 1), req1 ready stays 0; after req0 last, req1 forwarded exactly 2 cycles later.
- Burst: req1 write len 3, wstrobe 0xFF → four mem_ready beats, grant held through beats 0–2, released only on beat 3 with last.
- Fairness: both valid continuously for 6 transactions → grant sequence 0,1,0,1,0,1.
- Reset mid-burst: reset after beat 1 of a len 7 burst → next cycle mem_valid 0, grant_valid 0, rr_ptr 0; req1-only request afterwards is granted normally.
- Idle: no requests for 20 cycles → all outputs stay 0, state IDLE.
